// File: rtl/mem_stage_dbus_pkg.sv
// Shared definitions for the MiniMIPS32 memory stage: load/store ALU op codes,
// data-bus widths, FSM state encoding and the store byte-strobe helper.
package mem_stage_dbus_pkg;

  localparam int ALUOP_BUS_W  = 8;
  localparam int DBUS_WE_BUS  = 4;

  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_ADD = 8'h18;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_LB  = 8'h90;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_LBU = 8'h91;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_LH  = 8'h92;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_LHU = 8'h93;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_LW  = 8'h94;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_SB  = 8'h98;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_SH  = 8'h99;
  localparam logic [ALUOP_BUS_W-1:0] MINIMIPS32_SW  = 8'h9A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dbus_state_e;

  // Little-endian byte strobes; loads and non-memory ops yield 0000 (read).
  function automatic logic [DBUS_WE_BUS-1:0] store_strobe(
    input logic [ALUOP_BUS_W-1:0] aluop,
    input logic [1:0]             a
  );
    logic [DBUS_WE_BUS-1:0] we;
    case (aluop)
      MINIMIPS32_SB: we = 4'b0001 << a;
      MINIMIPS32_SH: we = a[1] ? 4'b1100 : 4'b0011;
      MINIMIPS32_SW: we = 4'b1111;
      default:       we = 4'b0000;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/mem_stage_dbus_load_fmt.sv
// Load-data formatter: selects the addressed byte/halfword lane of a bus word
// and sign- or zero-extends it according to the load op.
module mem_load_fmt
  import mem_stage_dbus_pkg::*;
(
  input  logic [ALUOP_BUS_W-1:0] aluop,
  input  logic [1:0]             a,
  input  logic [31:0]            data,
  output logic [31:0]            result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = data[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[a];
  assign half_sel = a[1] ? data[31:16] : data[15:0];

  always_comb begin
    case (aluop)
      MINIMIPS32_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MINIMIPS32_LBU: result = {24'h000000, byte_sel};
      MINIMIPS32_LH:  result = {{16{half_sel[15]}}, half_sel};
      MINIMIPS32_LHU: result = {16'h0000, half_sel};
      default:        result = data;
    endcase
  end

endmodule

// File: rtl/mem_stage_dbus.sv
// MiniMIPS32 memory stage: decodes loads/stores, runs a req/ack data-bus transfer
// with wait states and optional timeout, and formats load data for MEM/WB.
module mem_stage_dbus
  import mem_stage_dbus_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic [ALUOP_BUS_W-1:0] mem_aluop,
  input  logic [4:0]             mem_wa,
  input  logic                   mem_wreg,
  input  logic                   mem_whilo,
  input  logic                   mem_mreg,
  input  logic [31:0]            mem_wd,
  input  logic [31:0]            mem_din,
  input  logic [63:0]            mem_mul,
  input  logic                   dbus_ack,
  input  logic [31:0]            dbus_rdata,
  output logic                   dbus_req,
  output logic [DBUS_WE_BUS-1:0] dbus_we,
  output logic [31:0]            dbus_addr,
  output logic [31:0]            dbus_wdata,
  output logic                   stall_req_mem,
  output logic [4:0]             wb_wa,
  output logic                   wb_wreg,
  output logic [31:0]            wb_wd,
  output logic                   wb_whilo,
  output logic [63:0]            wb_hilo,
  output logic                   adr_err,
  output logic                   bus_err
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  dbus_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      rbuf_reg;
  logic             abort_reg;

  logic        is_load, is_store, is_half, is_word;
  logic        is_mem, misalign, mem_go, in_done, timeout_hit;
  logic [1:0]  a;
  logic [31:0] wdata_next;
  logic [31:0] load_data;

  assign a = mem_wd[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mem_aluop)
      MINIMIPS32_LB, MINIMIPS32_LBU: is_load = 1'b1;
      MINIMIPS32_LH, MINIMIPS32_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      MINIMIPS32_LW:                 begin is_load = 1'b1; is_word = 1'b1; end
      MINIMIPS32_SB:                 is_store = 1'b1;
      MINIMIPS32_SH:                 begin is_store = 1'b1; is_half = 1'b1; end
      MINIMIPS32_SW:                 begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem   = is_load | is_store;
  assign misalign = (is_half & a[0]) | (is_word & (a != 2'b00));
  assign mem_go   = is_mem & ~misalign;
  assign in_done  = (state_reg == ST_DONE);
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_comb begin
    case (mem_aluop)
      MINIMIPS32_SB: wdata_next = {4{mem_din[7:0]}};
      MINIMIPS32_SH: wdata_next = {2{mem_din[15:0]}};
      default:       wdata_next = mem_din;
    endcase
  end

  mem_load_fmt u_load_fmt (
    .aluop  (mem_aluop),
    .a      (a),
    .data   (rbuf_reg),
    .result (load_data)
  );

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      rbuf_reg   <= '0;
      abort_reg  <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= '0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mem_go) begin
            dbus_req   <= 1'b1;
            dbus_addr  <= {mem_wd[31:2], 2'b00};
            dbus_we    <= store_strobe(mem_aluop, a);
            dbus_wdata <= wdata_next;
            cnt_reg    <= '0;
            abort_reg  <= 1'b0;
            state_reg  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // An ack arriving on the timeout cycle still completes the transfer.
          if (dbus_ack) begin
            rbuf_reg  <= dbus_rdata;
            dbus_req  <= 1'b0;
            state_reg <= ST_DONE;
          end else if (timeout_hit) begin
            dbus_req  <= 1'b0;
            bus_err   <= 1'b1;
            abort_reg <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign stall_req_mem = ~cpu_rst &
                         (((state_reg == ST_IDLE) & mem_go) | (state_reg == ST_BUSY));
  assign adr_err  = ~cpu_rst & is_mem & misalign;
  assign wb_wa    = mem_wa;
  assign wb_whilo = ~cpu_rst & mem_whilo;
  assign wb_hilo  = mem_mul;
  assign wb_wd    = (in_done & is_load & mem_mreg) ? load_data : mem_wd;

  // Loads only write back once their data is in the buffer; aborts never write.
  always_comb begin
    wb_wreg = mem_wreg;
    if (cpu_rst || (is_mem && misalign))
      wb_wreg = 1'b0;
    else if (is_load && !in_done)
      wb_wreg = 1'b0;
    else if (in_done && abort_reg)
      wb_wreg = 1'b0;
  end

endmodule

// File: doc/mem_stage_dbus.md
Name: mem_stage_dbus

Overview:
- Memory-access stage of the MiniMIPS32 pipeline. Sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Decodes load/store ALU ops, drives a req/ack data bus with wait states and per-byte write strobes, and formats load data by sign or zero extension.
- Raises a stall request while a bus transfer is outstanding. All other instructions pass through with zero latency.

Parameters:
ACK_TIMEOUT, 255, maximum cycles waited for dbus_ack in BUSY before abort (0 = never time out)

Ports:
cpu_clk_50M  in  1  clock
cpu_rst  in  1  asynchronous active-high reset
mem_aluop  in  ALUOP_BUS(8)  ALU op from EX/MEM register
mem_wa  in  5  destination register address
mem_wreg  in  1  register write enable
mem_whilo  in  1  HI/LO write enable
mem_mreg  in  1  instruction is a load (memory-to-register)
mem_wd  in  32  ALU result; effective address for loads/stores
mem_din  in  32  store data (rt)
mem_mul  in  64  HI/LO value
dbus_ack  in  1  bus completion, valid only while dbus_req=1
dbus_rdata  in  32  read data, valid with dbus_ack
dbus_req  out  1  bus request (registered)
dbus_we  out  4  byte write strobes (0000 = read)
dbus_addr  out  32  word-aligned address {mem_wd[31:2],2'b00}
dbus_wdata  out  32  lane-replicated store data
stall_req_mem  out  1  freeze PC through EX/MEM and bubble MEM/WB
wb_wa  out  5  to MEM/WB
wb_wreg  out  1  to MEM/WB
wb_wd  out  32  load result or pass-through mem_wd
wb_whilo  out  1  to MEM/WB
wb_hilo  out  64  pass-through mem_mul
adr_err  out  1  misaligned access this cycle
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, cpu_rst=1):
  - FSM goes to IDLE; timeout counter and read buffer reset to 0.
  - dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, bus_err=0.
  - Combinational outputs are forced: stall_req_mem=0, wb_wreg=0, wb_whilo=0, adr_err=0.
  - Reset mid-transfer drops dbus_req immediately. Any late ack is ignored.
- Memory ops: MINIMIPS32_LB, LBU, LH, LHU, LW, SB, SH, SW (defined in defines.v). Little-endian; a = mem_wd[1:0].
- Misaligned access: halfword op with a[0]=1, or word op with a!=0.
  - adr_err=1 combinationally.
  - No bus cycle, no stall, wb_wreg=0.
- Strobes:
  - SB: 0001<<a.
  - SH: a[1] ? 1100 : 0011.
  - SW: 1111.
- Store data: SB replicates {4{din[7:0]}}; SH replicates {2{din[15:0]}}; SW sends din unchanged.
- FSM states IDLE, BUSY, DONE:
  - IDLE:
    - With an aligned memory op: stall_req_mem=1 combinationally.
    - Next edge registers dbus_req=1, addr, we, wdata and moves to BUSY.
    - With a non-memory op: outputs pass through, wb_wd=mem_wd.
  - BUSY:
    - stall_req_mem=1. Bus outputs are held stable. Counter increments each cycle.
    - On dbus_ack: capture dbus_rdata, drop dbus_req at the next edge, go to DONE.
    - On counter reaching ACK_TIMEOUT (when nonzero): drop dbus_req, pulse bus_err, go to DONE with the write suppressed (wb_wreg=0).
  - DONE:
    - stall_req_mem=0.
    - For loads, wb_wd = formatted buffer: LB/LH sign-extend, LBU/LHU zero-extend the selected lane (byte a, halfword a[1]).
    - Next edge returns to IDLE; the pipeline advances on that same edge.
- Minimum memory-op occupancy is 3 cycles (IDLE, BUSY with immediate ack, DONE). Each extra wait cycle adds 1.
- dbus_ack while not in BUSY is ignored.
- Store: wb_wreg=mem_wreg (normally 0). Load: wb_wreg=mem_wreg only in DONE; it is 0 in IDLE/BUSY so no bubble writes.
- Upstream must hold inputs constant while stall_req_mem=1.

Decomposition:
- defines.v gains the load/store ALUOP codes, the DBUS_WE_BUS width and the state encodings.
- One natural sub-module: mem_load_fmt (combinational lane select plus sign/zero extension), reused by the bench's reference model.

Test Plan:
- LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> dbus_addr=0x100, we=0000, stall 4 cycles, DONE wb_wd=0xDEADBEEF, wb_wreg=1.
- LB addr 0x103, rdata 0x80FF_0000 -> wb_wd=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x202, din 0x1234ABCD, immediate ack -> we=1100, wdata=0xABCDABCD, stall 2 cycles, wb_wreg=0.
- LW addr 0x101 -> adr_err=1, dbus_req stays 0, no stall, wb_wreg=0.
- ACK_TIMEOUT=4, SW with no ack -> dbus_req high 4 cycles, bus_err one pulse, stall released, later ack ignored.
- cpu_rst asserted in BUSY -> dbus_req and stall_req_mem are 0 asynchronously, FSM returns to IDLE; ALU op ADD with wd=7 after reset passes wb_wd=7 with no stall.
